psevdo_ram_arbiter: RTL and testbench
=====================================

Name: psevdo_ram_arbiter

Overview:
- Two-requester access controller for the 256x9 pseudo-RAM block (separate read and write ports, active-low strobes RDB/WRB).
- Owns RADDR/WADDR/DIn/RDB/WRB and returns read data from DO1 to the requester that issued the read.
- Arbitrates each port independently and round-robin: one write and one read issue per cycle.
- Enforces read-after-write ordering for same-address accesses.
- RAM RCLKS and WCLKS are tied to CLKS.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 9, RAM data width.
- RR_EN, 1, 1 = round-robin per port; 0 = fixed priority, A wins.

Ports:
- CLKS  in  1  system clock; also drives RAM RCLKS/WCLKS.
- RSTB  in  1  asynchronous active-low reset.
- REQA  in  1  requester A request; held until ACKA.
- WEA  in  1  A: 1 = write, 0 = read; stable while REQA=1.
- ADDRA  in  ADDR_W  A address; stable while REQA=1.
- DINA  in  DATA_W  A write data; stable while REQA=1.
- ACKA  out  1  A accepted this cycle (combinational).
- RVALIDA  out  1  A read data valid, one-cycle pulse.
- RDATAA  out  DATA_W  A read data; meaningful only when RVALIDA=1.
- REQB, WEB, ADDRB, DINB, ACKB, RVALIDB, RDATAB: same as the A set, for requester B.
- RADDR  out  ADDR_W  to RAM read address (registered).
- RDB  out  1  to RAM read strobe, active-low (registered).
- WADDR  out  ADDR_W  to RAM write address (registered).
- DIn  out  DATA_W  to RAM write data (registered).
- WRB  out  1  to RAM write strobe, active-low (registered).
- DO1  in  DATA_W  from RAM read data.

Behaviour:
- Reset (RSTB=0, async): RDB=1, WRB=1, RADDR=0, WADDR=0, DIn=0, RVALIDA/B=0, write and read priority pointers = A, read tag pipeline cleared. ACKx=0 while RSTB=0.
- Transfer rule: transfer happens at the rising edge where REQx=1 and ACKx=1. Requester may drop REQ or present a new request in the following cycle.
- Write arbitration: among requesters with REQ=1 and WE=1, grant the one at the write pointer if it is requesting, else the other.
  - On a grant, the write pointer moves to the non-granted requester (RR_EN=1).
  - No grant means no pointer change.
- Read arbitration: same rule over REQ=1, WE=0, using a separate read pointer.
- Hazard: if the read candidate's address equals the write grant's address in the same cycle, the read is not granted (ACK=0) and the read pointer does not move. The read is granted next cycle at the earliest.
- ACKx = write grant to x OR read grant to x. A requester holds at most one request at a time.
- Write issue: on transfer at edge k, WADDR<=ADDRx, DIn<=DINx, WRB<=0. RAM writes at edge k+1. With no write grant, WRB<=1 and WADDR/DIn hold.
- Read issue: on transfer at edge k, RADDR<=ADDRx, RDB<=0, tag<=x. RAM captures at edge k+1. RVALIDx=1 for the cycle after edge k+1, with RDATAx=DO1 in that cycle.
  - Read latency: 2 edges from accept to data.
  - Back-to-back reads sustain 1 per cycle.
  - With no read grant, RDB<=1 and RADDR holds.
- RDATAA and RDATAB both mirror DO1. Only the tagged RVALID pulses.
- Ordering: a write accepted at edge k is visible to any read accepted at edge k+1 or later. A same-cycle same-address pair is split by the hazard rule.
- Simultaneous A-write and B-read (different addresses): both ACK in the same cycle.
- Starvation: with RR_EN=1 and both continuously requesting the same port, grants alternate A, B, A, B.
- Reset mid-operation: in-flight reads are dropped with no RVALID; a pending RAM write strobe is cancelled (WRB forced to 1).
- Address wrap: none needed; full ADDR_W range, 255 is a valid address.

Test Plan:
- Reset, idle: RDB=1, WRB=1, ACKA=ACKB=0, RVALIDA/B=0.
- A writes 0x1A5 to addr 0x10, then A reads 0x10: ACKA each cycle; RDB low for one cycle; RVALIDA pulses 2 edges after the read accept with RDATAA=0x1A5; RVALIDB stays 0.
- A and B both hold write requests (addrs 0x01/0x02) for 4 cycles: ACK sequence A,B,A,B; WADDR sequence 0x01,0x02,0x01,0x02.
- Same cycle: A writes 0x0FF to 0x33, B reads 0x33: ACKA=1, ACKB=0; ACKB=1 next cycle; RVALIDB returns 0x0FF, not the old value.
- Same cycle: A writes addr 0x05, B reads addr 0x06: ACKA=ACKB=1 in the same cycle; both strobes low the next cycle.
- B read accepted, RSTB pulsed low before the data cycle: no RVALIDB; all outputs at reset values; the next request after RSTB=1 is served normally.

Source files
------------

// File: rtl/psevdo_ram_arbiter.sv
// Two-requester access controller for the 256x9 pseudo-RAM: independent write and read
// arbitration, same-address read-after-write protection, and tagged read-data return.
module psevdo_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              CLKS,
  input  logic              RSTB,
  input  logic              REQA,
  input  logic              WEA,
  input  logic [ADDR_W-1:0] ADDRA,
  input  logic [DATA_W-1:0] DINA,
  output logic              ACKA,
  output logic              RVALIDA,
  output logic [DATA_W-1:0] RDATAA,
  input  logic              REQB,
  input  logic              WEB,
  input  logic [ADDR_W-1:0] ADDRB,
  input  logic [DATA_W-1:0] DINB,
  output logic              ACKB,
  output logic              RVALIDB,
  output logic [DATA_W-1:0] RDATAB,
  output logic [ADDR_W-1:0] RADDR,
  output logic              RDB,
  output logic [ADDR_W-1:0] WADDR,
  output logic [DATA_W-1:0] DIn,
  output logic              WRB,
  input  logic [DATA_W-1:0] DO1
);

  // Pointers name the requester that currently holds priority: 0 = A, 1 = B.
  logic wptr_reg, wptr_next;
  logic rptr_reg, rptr_next;
  logic rd_tag_reg;
  logic rvalid_a_reg, rvalid_b_reg;

  logic wcand_a, wcand_b, rcand_a, rcand_b;
  logic wgnt_a, wgnt_b, rgnt_a, rgnt_b;
  logic w_any, r_any, r_sel_b, hazard;
  logic w_pri_b, r_pri_b;
  logic [ADDR_W-1:0] w_addr_c, r_addr_c;
  logic [DATA_W-1:0] w_data_c;

  always_comb begin
    wcand_a = RSTB & REQA & WEA;
    wcand_b = RSTB & REQB & WEB;
    rcand_a = RSTB & REQA & ~WEA;
    rcand_b = RSTB & REQB & ~WEB;

    w_pri_b = RR_EN ? wptr_reg : 1'b0;
    r_pri_b = RR_EN ? rptr_reg : 1'b0;

    wgnt_b   = wcand_b & (~wcand_a | w_pri_b);
    wgnt_a   = wcand_a & ~wgnt_b;
    w_any    = wgnt_a | wgnt_b;
    w_addr_c = wgnt_b ? ADDRB : ADDRA;
    w_data_c = wgnt_b ? DINB : DINA;

    r_sel_b  = rcand_b & (~rcand_a | r_pri_b);
    r_any    = rcand_a | rcand_b;
    r_addr_c = r_sel_b ? ADDRB : ADDRA;

    // A read hitting the address being written this cycle waits one cycle so it sees the new data.
    hazard = r_any & w_any & (r_addr_c == w_addr_c);
    rgnt_b = r_sel_b & ~hazard;
    rgnt_a = rcand_a & ~r_sel_b & ~hazard;

    ACKA = wgnt_a | rgnt_a;
    ACKB = wgnt_b | rgnt_b;

    wptr_next = (RR_EN && w_any) ? wgnt_a : wptr_reg;
    rptr_next = (RR_EN && (rgnt_a | rgnt_b)) ? rgnt_a : rptr_reg;
  end

  always_ff @(posedge CLKS or negedge RSTB) begin
    if (!RSTB) begin
      wptr_reg     <= 1'b0;
      rptr_reg     <= 1'b0;
      WRB          <= 1'b1;
      WADDR        <= '0;
      DIn          <= '0;
      RDB          <= 1'b1;
      RADDR        <= '0;
      rd_tag_reg   <= 1'b0;
      rvalid_a_reg <= 1'b0;
      rvalid_b_reg <= 1'b0;
    end else begin
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      WRB      <= ~w_any;
      if (w_any) begin
        WADDR <= w_addr_c;
        DIn   <= w_data_c;
      end
      RDB <= ~(rgnt_a | rgnt_b);
      if (rgnt_a | rgnt_b) begin
        RADDR      <= r_addr_c;
        rd_tag_reg <= rgnt_b;
      end
      // RAM samples RADDR on the edge after issue; data is on DO1 in the following cycle.
      rvalid_a_reg <= ~RDB & ~rd_tag_reg;
      rvalid_b_reg <= ~RDB & rd_tag_reg;
    end
  end

  assign RVALIDA = rvalid_a_reg;
  assign RVALIDB = rvalid_b_reg;
  assign RDATAA  = DO1;
  assign RDATAB  = DO1;

endmodule

// File: tb/tb_psevdo_ram_arbiter.sv
// Bench for psevdo_ram_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against an abstract memory/arbitration model.
module tb_psevdo_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 9;

  logic CLKS = 1'b0;
  logic RSTB = 1'b0;
  logic REQA = 1'b0, WEA = 1'b0, REQB = 1'b0, WEB = 1'b0;
  logic [AW-1:0] ADDRA = '0, ADDRB = '0;
  logic [DW-1:0] DINA = '0, DINB = '0;
  logic ACKA, ACKB, RVALIDA, RVALIDB, RDB, WRB;
  logic [DW-1:0] RDATAA, RDATAB, DIn, DO1;
  logic [AW-1:0] RADDR, WADDR;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 CLKS = ~CLKS;

  psevdo_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
    .CLKS(CLKS), .RSTB(RSTB),
    .REQA(REQA), .WEA(WEA), .ADDRA(ADDRA), .DINA(DINA),
    .ACKA(ACKA), .RVALIDA(RVALIDA), .RDATAA(RDATAA),
    .REQB(REQB), .WEB(WEB), .ADDRB(ADDRB), .DINB(DINB),
    .ACKB(ACKB), .RVALIDB(RVALIDB), .RDATAB(RDATAB),
    .RADDR(RADDR), .RDB(RDB), .WADDR(WADDR), .DIn(DIn), .WRB(WRB),
    .DO1(DO1)
  );

  // Pseudo-RAM: synchronous write and synchronous read on the shared clock.
  logic [DW-1:0] ram [0:255];
  always @(posedge CLKS) begin
    if (!WRB) ram[WADDR] <= DIn;
    if (!RDB) DO1 <= ram[RADDR];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Winner index per port: -1 none, 0 = A, 1 = B.
  function automatic void arb(input logic ra, input logic wa, input logic [AW-1:0] aa,
                              input logic rb, input logic wb, input logic [AW-1:0] ab,
                              input logic wp, input logic rp,
                              output int wwin, output int rwin);
    wwin = -1;
    rwin = -1;
    if (ra && wa && rb && wb) wwin = wp ? 1 : 0;
    else if (ra && wa)        wwin = 0;
    else if (rb && wb)        wwin = 1;
    if (ra && !wa && rb && !wb) rwin = rp ? 1 : 0;
    else if (ra && !wa)         rwin = 0;
    else if (rb && !wb)         rwin = 1;
    if (wwin >= 0 && rwin >= 0)
      if ((rwin == 0 ? aa : ab) == (wwin == 0 ? aa : ab)) rwin = -1;
  endfunction

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    bit            known;
    longint        due;
  } rd_t;

  rd_t           q[$];
  logic          m_wp = 1'b0, m_rp = 1'b0;
  logic [DW-1:0] m_mem [0:255];
  bit            m_known [0:255];
  bit            pw_v = 1'b0;
  logic [AW-1:0] pw_a;
  logic [DW-1:0] pw_d;
  logic          e_wrb = 1'b1, e_rdb = 1'b1;
  logic [AW-1:0] e_waddr = '0, e_raddr = '0;
  logic [DW-1:0] e_din = '0;
  longint        ecnt = 0;
  bit            m_ga = 1'b0, m_gb = 1'b0;
  int            m_ww, m_rw;
  logic [AW-1:0] m_ra;
  rd_t           m_ent;

  // Abstract model: a write becomes visible to reads accepted from the next edge on.
  always @(posedge CLKS or negedge RSTB) begin
    if (!RSTB) begin
      m_wp = 1'b0; m_rp = 1'b0; pw_v = 1'b0;
      q.delete();
      e_wrb = 1'b1; e_rdb = 1'b1; e_waddr = '0; e_raddr = '0; e_din = '0;
      m_ga = 1'b0; m_gb = 1'b0;
    end else begin
      ecnt++;
      if (pw_v) begin
        m_mem[pw_a]   = pw_d;
        m_known[pw_a] = 1'b1;
      end
      pw_v = 1'b0;
      arb(REQA, WEA, ADDRA, REQB, WEB, ADDRB, m_wp, m_rp, m_ww, m_rw);
      m_ga = (m_ww == 0) || (m_rw == 0);
      m_gb = (m_ww == 1) || (m_rw == 1);
      if (m_ww >= 0) begin
        pw_v = 1'b1;
        pw_a = (m_ww == 0) ? ADDRA : ADDRB;
        pw_d = (m_ww == 0) ? DINA : DINB;
        e_wrb = 1'b0; e_waddr = pw_a; e_din = pw_d;
        m_wp = (m_ww == 0);
      end else e_wrb = 1'b1;
      if (m_rw >= 0) begin
        m_ra = (m_rw == 0) ? ADDRA : ADDRB;
        m_ent.tag = m_rw; m_ent.data = m_mem[m_ra]; m_ent.known = m_known[m_ra];
        m_ent.due = ecnt + 1;
        q.push_back(m_ent);
        e_rdb = 1'b0; e_raddr = m_ra;
        m_rp = (m_rw == 0);
      end else e_rdb = 1'b1;
    end
  end

  int c_ww, c_rw;
  bit exp_va, exp_vb;
  always @(negedge CLKS) begin
    if (!RSTB) begin
      chk("rst_acka", ACKA, 0);   chk("rst_ackb", ACKB, 0);
      chk("rst_rdb", RDB, 1);     chk("rst_wrb", WRB, 1);
      chk("rst_raddr", RADDR, 0); chk("rst_waddr", WADDR, 0); chk("rst_din", DIn, 0);
      chk("rst_rvalida", RVALIDA, 0); chk("rst_rvalidb", RVALIDB, 0);
    end else begin
      arb(REQA, WEA, ADDRA, REQB, WEB, ADDRB, m_wp, m_rp, c_ww, c_rw);
      chk("acka", ACKA, (c_ww == 0) || (c_rw == 0));
      chk("ackb", ACKB, (c_ww == 1) || (c_rw == 1));
      chk("wrb", WRB, e_wrb);     chk("waddr", WADDR, e_waddr); chk("din", DIn, e_din);
      chk("rdb", RDB, e_rdb);     chk("raddr", RADDR, e_raddr);
      while (q.size() > 0 && q[0].due < ecnt) void'(q.pop_front());
      exp_va = 1'b0; exp_vb = 1'b0;
      if (q.size() > 0 && q[0].due == ecnt) begin
        exp_va = (q[0].tag == 0);
        exp_vb = (q[0].tag == 1);
      end
      chk("rvalida", RVALIDA, exp_va);
      chk("rvalidb", RVALIDB, exp_vb);
      if (exp_va && q[0].known) chk("rdataa", RDATAA, q[0].data);
      if (exp_vb && q[0].known) chk("rdatab", RDATAB, q[0].data);
    end
  end

  task automatic tick;
    @(posedge CLKS);
    #1;
  endtask

  task automatic do_reset;
    REQA = 1'b0; REQB = 1'b0;
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? AW'(255) : AW'(r);
  endfunction

  logic [AW-1:0] seq_addr [0:3];

  initial begin
    seq_addr[0] = 8'h01; seq_addr[1] = 8'h02; seq_addr[2] = 8'h01; seq_addr[3] = 8'h02;
    repeat (2) tick();
    chk("lit_rst_rdb", RDB, 1); chk("lit_rst_wrb", WRB, 1);
    chk("lit_rst_ack", {ACKA, ACKB}, 0); chk("lit_rst_rvalid", {RVALIDA, RVALIDB}, 0);
    RSTB = 1'b1;
    tick();

    // A writes 0x1A5 to 0x10, then reads it back.
    REQA = 1; WEA = 1; ADDRA = 8'h10; DINA = 9'h1A5;
    #1 chk("lit_w_acka", ACKA, 1);
    tick();
    chk("lit_w_strobe", {WRB, WADDR, DIn}, {1'b0, 8'h10, 9'h1A5});
    WEA = 0;
    #1 chk("lit_r_acka", ACKA, 1);
    tick();
    REQA = 0;
    chk("lit_r_strobe", {RDB, RADDR}, {1'b0, 8'h10});
    tick();
    chk("lit_r_valid", {RVALIDA, RVALIDB}, 2'b10);
    chk("lit_r_data", RDATAA, 9'h1A5);
    chk("lit_r_rdb_hi", RDB, 1);
    tick();
    chk("lit_r_pulse_end", RVALIDA, 0);

    // Both hold writes: grants alternate A, B, A, B.
    do_reset();
    REQA = 1; WEA = 1; ADDRA = 8'h01; DINA = 9'h011;
    REQB = 1; WEB = 1; ADDRB = 8'h02; DINB = 9'h022;
    for (int i = 0; i < 4; i++) begin
      #1 chk("lit_rr_ack", {ACKA, ACKB}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      chk("lit_rr_waddr", WADDR, seq_addr[i]);
    end
    REQA = 0; REQB = 0;

    // Same-address write/read in one cycle: the read waits and sees the new data.
    do_reset();
    REQA = 1; WEA = 1; ADDRA = 8'h33; DINA = 9'h0FF;
    REQB = 1; WEB = 0; ADDRB = 8'h33;
    #1 chk("lit_hz_ack", {ACKA, ACKB}, 2'b10);
    tick();
    REQA = 0;
    #1 chk("lit_hz_ackb", ACKB, 1);
    tick();
    REQB = 0;
    tick();
    chk("lit_hz_valid", {RVALIDA, RVALIDB}, 2'b01);
    chk("lit_hz_data", RDATAB, 9'h0FF);

    // Different addresses: both accepted together.
    do_reset();
    REQA = 1; WEA = 1; ADDRA = 8'h05; DINA = 9'h123;
    REQB = 1; WEB = 0; ADDRB = 8'h06;
    #1 chk("lit_par_ack", {ACKA, ACKB}, 2'b11);
    tick();
    chk("lit_par_strobes", {WRB, RDB}, 2'b00);
    REQA = 0; REQB = 0;

    // Reset lands while a read is in flight.
    REQB = 1; WEB = 0; ADDRB = 8'h05;
    #1 chk("lit_mr_ackb", ACKB, 1);
    tick();
    REQB = 0;
    RSTB = 0;
    #1 chk("lit_mr_outs", {RDB, WRB, RVALIDB, RADDR}, {3'b110, 8'h00});
    tick();
    chk("lit_mr_novalid", RVALIDB, 0);
    RSTB = 1;
    REQB = 1;
    #1 chk("lit_mr_again_ack", ACKB, 1);
    tick();
    REQB = 0;
    tick();
    chk("lit_mr_again_valid", RVALIDB, 1);
    chk("lit_mr_again_data", RDATAB, 9'h123);
    tick();

    // Random traffic, occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      if (!RSTB) RSTB = 1;
      else if ($urandom_range(0, 399) == 0) RSTB = 0;
      if (!REQA || m_ga) begin
        if ($urandom_range(0, 9) < 7) begin
          REQA = 1; WEA = 1'($urandom_range(0, 1)); ADDRA = rand_addr(); DINA = DW'($urandom);
        end else REQA = 0;
      end
      if (!REQB || m_gb) begin
        if ($urandom_range(0, 9) < 7) begin
          REQB = 1; WEB = 1'($urandom_range(0, 1)); ADDRB = rand_addr(); DINB = DW'($urandom);
        end else REQB = 0;
      end
      tick();
    end
    RSTB = 1; REQA = 0; REQB = 0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
